ctrl_cmd_sequencer: RTL
=======================

// Module: ctrl_cmd_sequencer
// PURPOSE
//  Command-side initiator for the datapath controller: accepts host commands (load/clr/comp + op), buffers them
//  in a small FIFO, issues each to the controller as a one-cycle strobe, holds off for the op's fixed latency,
//  then pulses done. Sits between host/test logic and the controller's op/load/comp/clr inputs.
// PARAMETERS
//  DEPTH       4   command FIFO entries (power of 2, >=2)
//  MUL_CYCLES  8   controller cycles for any MUL op after the comp strobe (>=2)
//  ALU_CYCLES  1   controller cycles for ADD/XOR after the comp strobe (>=1)
// PORTS
//  clk          in   1  clock, rising edge
//  clr          in   1  reset, asynchronous, active-low
//  cmd_valid    in   1  host command valid
//  cmd_ready    out  1  FIFO not full
//  cmd_kind     in   2  00 LOAD, 01 CLR, 10 COMP, 11 reserved
//  cmd_op       in   3  op code, used for COMP (LOAD/CLR: forwarded unchanged)
//  op           out  3  op to controller, held from issue through end of wait
//  load         out  1  one-cycle load strobe
//  comp         out  1  one-cycle compute strobe
//  clr_cmd      out  1  one-cycle clear strobe (controller clr input)
//  busy         out  1  high in ISSUE/WAIT
//  done         out  1  one-cycle pulse when a command's latency expires
//  err          out  1  sticky illegal-command flag (CMD_ERR_EN only; else tied 0)
// BEHAVIOUR
//  Reset (clr=0, any time, incl. mid-op): FIFO empty, state IDLE, op=000, all strobes/busy/done/err=0; in-flight lost.
//  Accept on cmd_valid&&cmd_ready; cmd_ready=!full, registered from occupancy. Push and pop in the same cycle
//  are legal when full (pop frees the slot next cycle only; cmd_ready does not combinationally reflect pop).
//  Op codes: 000 ADD, 001 XOR, 010 MUL1, 011 MUL2, 100 MUL3, 101 MUL4, 110/111 reserved.
//  Latency L: LOAD=1, CLR=1, COMP ADD/XOR=ALU_CYCLES, COMP MUL*=MUL_CYCLES.
//  FSM: IDLE -> ISSUE when FIFO non-empty (pop in that cycle, registered outputs).
//   ISSUE: exactly one of load/comp/clr_cmd=1 for one cycle, op valid; counter cnt<=L; ->WAIT.
//   WAIT: cnt decrements each cycle; when cnt==1: done=1 next cycle; -> ISSUE if FIFO non-empty, else IDLE.
//  Back-to-back: strobes for consecutive commands are exactly L+1 cycles apart; no idle bubble.
//  op held stable from ISSUE until the next ISSUE; returns to 000 only on reset.
//  done and the next ISSUE strobe may coincide; done never coincides with reset.
//  cnt width = $clog2(MUL_CYCLES+1); never wraps (loaded only in ISSUE).
// CONFIGURATION
//  CMD_ERR_EN defined: cmd_kind=11 or COMP with op 110/111 is dropped at the FIFO input (still handshaken,
//   cmd_ready unaffected), err set and held until reset; no strobe, no done.
//  CMD_ERR_EN undefined: such commands are queued and issued as a 1-cycle no-op: ISSUE with no strobe,
//   op forwarded, L=1, done pulsed normally; err tied 0.
// STRUCTURE
//  Package ctrl_seq_pkg: cmd_kind and op code localparams, FSM state encoding (IDLE/ISSUE/WAIT),
//   latency lookup function lat_of(kind, op).
//  One sub-module: ctrl_cmd_fifo (sync FIFO, DEPTH x 5 bits, async active-low clr, full/empty flags).
// TESTING
//  1 Reset mid-MUL (clr low in WAIT, cnt=4) -> next cycle busy=0, op=000, cmd_ready=1, no done.
//  2 LOAD, CLR, COMP ADD queued at once -> load@t, clr_cmd@t+2, comp@t+4, done@t+2,t+4,t+6 (ALU_CYCLES=1).
//  3 COMP MUL3 (op=100) -> comp one cycle, op=100 held 9 cycles, done 9 cycles after the strobe (MUL_CYCLES=8).
//  4 Push 5 commands with DEPTH=4 while busy -> cmd_ready=0 after 4th; 5th accepted after first pop; order kept.
//  5 COMP op=111: with CMD_ERR_EN -> err=1 sticky, no strobe/done; without -> no strobe, done 2 cycles later.
//  6 Push on the same cycle FIFO pops from full -> push held off one cycle; no loss, no duplicate issue.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the controller command sequencer: command kinds,
// op codes, FSM state encoding and the per-command latency lookup.
package ctrl_seq_pkg;

  localparam int CMD_W = 5;  // {kind[1:0], op[2:0]}

  localparam logic [1:0] KIND_LOAD = 2'b00;
  localparam logic [1:0] KIND_CLR  = 2'b01;
  localparam logic [1:0] KIND_COMP = 2'b10;
  localparam logic [1:0] KIND_RSVD = 2'b11;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_MUL1 = 3'b010;
  localparam logic [2:0] OP_MUL2 = 3'b011;
  localparam logic [2:0] OP_MUL3 = 3'b100;
  localparam logic [2:0] OP_MUL4 = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_e;

  // Reserved kind, or COMP carrying a reserved op code.
  function automatic logic cmd_illegal(logic [1:0] kind, logic [2:0] op);
    return (kind == KIND_RSVD) || ((kind == KIND_COMP) && (op == 3'b110 || op == 3'b111));
  endfunction

  // Cycles the controller needs after the strobe; illegal commands act as a 1-cycle no-op.
  function automatic int lat_of(logic [1:0] kind, logic [2:0] op, int alu_cycles, int mul_cycles);
    if (cmd_illegal(kind, op)) return 1;
    if (kind == KIND_COMP) begin
      if (op == OP_ADD || op == OP_XOR) return alu_cycles;
      return mul_cycles;
    end
    return 1;
  endfunction

endpackage

// File: rtl/ctrl_cmd_fifo.sv
// Small synchronous command FIFO with registered full flag and async active-low clear.
// A push while full is honoured only if a pop happens in the same cycle.
module ctrl_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          do_push, do_pop;

  // Next-state for storage, pointers, occupancy and the registered full flag.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && (!full_q || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_ONE;
    end
    full_d = (count_d == FULL_CNT);
  end

  // FIFO registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = (count_q == '0);

endmodule

// File: rtl/ctrl_cmd_sequencer.sv
// Command-side initiator for the datapath controller. Host commands are queued,
// issued one at a time as a single-cycle strobe, and followed by a fixed
// latency wait ending in a done pulse.
// Optional feature macro: CMD_ERR_EN (drop illegal commands at the input and
// raise a sticky err flag; otherwise they run as 1-cycle no-ops).
//
// Handshake: a command is accepted on any rising edge where cmd_valid && cmd_ready;
// cmd_ready is registered (FIFO not full) and never reacts combinationally to a pop.
module ctrl_cmd_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MUL_CYCLES = 8,
  parameter int ALU_CYCLES = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_kind,
  input  logic [2:0] cmd_op,
  output logic [2:0] op,
  output logic       load,
  output logic       comp,
  output logic       clr_cmd,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             accept, push, pop;
  logic [CMD_W-1:0] head;
  logic             fifo_full, fifo_empty;
  logic [1:0]       head_kind;
  logic [2:0]       head_op;
  logic             last_wait;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       kind_q, kind_d;
  logic             load_q, load_d;
  logic             comp_q, comp_d;
  logic             clr_cmd_q, clr_cmd_d;
  logic             done_q, done_d;

  assign accept    = cmd_valid && cmd_ready;
  assign cmd_ready = !fifo_full;
  assign head_kind = head[4:3];
  assign head_op   = head[2:0];
  assign last_wait = (state_q == ST_WAIT) && (cnt_q == CNT_ONE);

`ifdef CMD_ERR_EN
  logic err_q, err_d;

  // Illegal commands are handshaken but never reach the queue; err latches until reset.
  always_comb begin
    push  = accept && !cmd_illegal(cmd_kind, cmd_op);
    err_d = err_q || (accept && cmd_illegal(cmd_kind, cmd_op));
  end

  // Sticky error flag.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`else
  assign push = accept;
  assign err  = 1'b0;
`endif

  ctrl_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .clr       (clr),
    .push      (push),
    .push_data ({cmd_kind, cmd_op}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State register and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= 3'b000;
      kind_q    <= 2'b00;
      load_q    <= 1'b0;
      comp_q    <= 1'b0;
      clr_cmd_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      kind_q    <= kind_d;
      load_q    <= load_d;
      comp_q    <= comp_d;
      clr_cmd_q <= clr_cmd_d;
      done_q    <= done_d;
    end
  end

  // Next-state: pop the head whenever the sequencer is free to issue, with no bubble after WAIT.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (cnt_q == CNT_ONE) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values: strobe decode at pop, latency load in ISSUE, countdown in WAIT.
  always_comb begin
    op_d      = op_q;
    kind_d    = kind_q;
    load_d    = 1'b0;
    comp_d    = 1'b0;
    clr_cmd_d = 1'b0;
    cnt_d     = cnt_q;
    done_d    = last_wait;
    if (pop) begin
      op_d   = head_op;
      kind_d = head_kind;
      if (!cmd_illegal(head_kind, head_op)) begin
        load_d    = (head_kind == KIND_LOAD);
        clr_cmd_d = (head_kind == KIND_CLR);
        comp_d    = (head_kind == KIND_COMP);
      end
    end
    if (state_q == ST_ISSUE) begin
      cnt_d = CNT_W'(lat_of(kind_q, op_q, ALU_CYCLES, MUL_CYCLES));
    end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  assign op      = op_q;
  assign load    = load_q;
  assign comp    = comp_q;
  assign clr_cmd = clr_cmd_q;
  assign done    = done_q;
  assign busy    = (state_q != ST_IDLE);

endmodule
